// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with modulus, step, prescaler, load, wrap or
// saturate mode, and registered overflow/underflow pulses with sticky flags.
module param_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             updown,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic             match
);

  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [WIDTH:0]  MAX_EXT    = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]  MOD_EXT    = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH-1:0] MAX_W     = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

  // Limits an input operand to the counter's terminal value, widened by one bit.
  function automatic logic [WIDTH:0] clamp_to_max(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] v_ext;
    v_ext = {1'b0, v};
    if (v_ext > MAX_EXT) begin
      clamp_to_max = MAX_EXT;
    end else begin
      clamp_to_max = v_ext;
    end
  endfunction

  logic [PW-1:0]    presc_r;
  logic [PW-1:0]    presc_nxt_s;
  logic             tick_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;
  logic             ovf_pulse_r;
  logic             unf_pulse_r;
  logic             ovf_sticky_r;
  logic             unf_sticky_r;
  logic [WIDTH:0]   step_eff_s;
  logic [WIDTH:0]   load_eff_s;
  logic [WIDTH:0]   count_ext_s;
  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH:0]   up_wrap_s;
  logic [WIDTH:0]   down_diff_s;
  logic [WIDTH:0]   down_wrap_s;

  // Prescaler phase: advances on enabled cycles, ticks on its last phase, load restarts it.
  always_comb begin
    presc_nxt_s = presc_r;
    tick_s      = 1'b0;
    if (load) begin
      presc_nxt_s = PRESC_ZERO;
    end else if (en) begin
      if (presc_r == PRESC_LAST) begin
        presc_nxt_s = PRESC_ZERO;
        tick_s      = 1'b1;
      end else begin
        presc_nxt_s = presc_r + PRESC_ONE;
      end
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // Widened operands so the rail compares see the untruncated sums.
  always_comb begin
    step_eff_s  = clamp_to_max(step);
    load_eff_s  = clamp_to_max(load_val);
    count_ext_s = {1'b0, count_r};
    up_sum_s    = count_ext_s + step_eff_s;
    up_wrap_s   = up_sum_s - MOD_EXT;
    down_diff_s = count_ext_s - step_eff_s;
    down_wrap_s = count_ext_s + MOD_EXT - step_eff_s;
  end

  // Next count and rail-crossing flags: load beats tick, tick beats hold.
  always_comb begin
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    unf_nxt_s   = 1'b0;
    if (load) begin
      count_nxt_s = load_eff_s[WIDTH-1:0];
    end else if (tick_s) begin
      if (updown) begin
        if (up_sum_s > MAX_EXT) begin
          ovf_nxt_s = 1'b1;
          if (SATURATE) begin
            count_nxt_s = MAX_W;
          end else begin
            count_nxt_s = up_wrap_s[WIDTH-1:0];
          end
        end else begin
          count_nxt_s = up_sum_s[WIDTH-1:0];
        end
      end else begin
        if (count_ext_s >= step_eff_s) begin
          count_nxt_s = down_diff_s[WIDTH-1:0];
        end else begin
          unf_nxt_s = 1'b1;
          if (SATURATE) begin
            count_nxt_s = ZERO_W;
          end else begin
            count_nxt_s = down_wrap_s[WIDTH-1:0];
          end
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State and output registers; a new crossing outranks a same-cycle flag clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r      <= PRESC_ZERO;
      count_r      <= ZERO_W;
      ovf_pulse_r  <= 1'b0;
      unf_pulse_r  <= 1'b0;
      ovf_sticky_r <= 1'b0;
      unf_sticky_r <= 1'b0;
    end else begin
      presc_r      <= presc_nxt_s;
      count_r      <= count_nxt_s;
      ovf_pulse_r  <= ovf_nxt_s;
      unf_pulse_r  <= unf_nxt_s;
      ovf_sticky_r <= ovf_nxt_s | (ovf_sticky_r & ~clr_flags);
      unf_sticky_r <= unf_nxt_s | (unf_sticky_r & ~clr_flags);
    end
  end

  assign count      = count_r;
  assign ovf_pulse  = ovf_pulse_r;
  assign unf_pulse  = unf_pulse_r;
  assign ovf_sticky = ovf_sticky_r;
  assign unf_sticky = unf_sticky_r;
  assign match      = (count_r == cmp_val);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: a wrap/prescale-1 and a saturate/prescale-3 counter share
// randomised stimulus and are compared against an arithmetic reference model.
module tb_param_updown_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         rst, en, load, updown, clr_flags;
  logic [W-1:0] load_val, step, cmp_val;
  logic [W-1:0] w_count, s_count;
  logic         w_ovf, w_unf, w_ovfs, w_unfs, w_match;
  logic         s_ovf, s_unf, s_ovfs, s_unfs, s_match;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .updown(updown),
    .step(step), .cmp_val(cmp_val), .clr_flags(clr_flags), .count(w_count),
    .ovf_pulse(w_ovf), .unf_pulse(w_unf), .ovf_sticky(w_ovfs), .unf_sticky(w_unfs),
    .match(w_match));

  param_updown_counter #(.WIDTH(W), .MAX_VAL(MAXV), .SATURATE(1'b1), .PRESCALE(3)) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .updown(updown),
    .step(step), .cmp_val(cmp_val), .clr_flags(clr_flags), .count(s_count),
    .ovf_pulse(s_ovf), .unf_pulse(s_unf), .ovf_sticky(s_ovfs), .unf_sticky(s_unfs),
    .match(s_match));

  typedef struct {
    int cnt;
    int en_cycles;
    bit ovf;
    bit unf;
    bit ovfs;
    bit unfs;
  } mstate_t;

  typedef struct {
    int cnt;
    bit ovf;
    bit unf;
    bit ovfs;
    bit unfs;
    int cmp;
  } exp_t;

  exp_t    q_w[$];
  exp_t    q_s[$];
  mstate_t m_w, m_s;
  int      checks = 0;
  int      errors = 0;

  // Reference: a tick happens on every presc-th enabled cycle since reset/load.
  function automatic mstate_t model_next(mstate_t s, int maxv, bit sat, int presc,
                                         bit r, bit ld, int lv, bit e, bit ud,
                                         int st, bit clr);
    mstate_t n;
    bit      tick;
    int      se;
    int      t;
    n     = s;
    n.ovf = 1'b0;
    n.unf = 1'b0;
    tick  = 1'b0;
    if (r) begin
      n.cnt = 0; n.en_cycles = 0; n.ovfs = 1'b0; n.unfs = 1'b0;
      return n;
    end
    if (e) begin
      n.en_cycles = (s.en_cycles + 1) % presc;
      tick        = (n.en_cycles == 0);
    end
    if (ld) begin
      n.cnt       = (lv > maxv) ? maxv : lv;
      n.en_cycles = 0;
    end else if (tick) begin
      se = (st > maxv) ? maxv : st;
      t  = ud ? s.cnt + se : s.cnt - se;
      if (t > maxv) begin
        n.ovf = 1'b1;
        n.cnt = sat ? maxv : t - (maxv + 1);
      end else if (t < 0) begin
        n.unf = 1'b1;
        n.cnt = sat ? 0 : t + maxv + 1;
      end else begin
        n.cnt = t;
      end
    end
    n.ovfs = n.ovf | (s.ovfs & !clr);
    n.unfs = n.unf | (s.unfs & !clr);
    return n;
  endfunction

  function automatic exp_t to_exp(mstate_t s, int cv);
    exp_t x;
    x.cnt = s.cnt; x.ovf = s.ovf; x.unf = s.unf;
    x.ovfs = s.ovfs; x.unfs = s.unfs; x.cmp = cv;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the predicted post-edge state goes to the scoreboards.
  task automatic drive(input bit r, input bit ld, input int lv, input bit e,
                       input bit ud, input int st, input int cv, input bit clr);
    @(negedge clk);
    rst = r; load = ld; load_val = lv[W-1:0]; en = e;
    updown = ud; step = st[W-1:0]; cmp_val = cv[W-1:0]; clr_flags = clr;
    m_w = model_next(m_w, MAXV, 1'b0, 1, r, ld, lv, e, ud, st, clr);
    m_s = model_next(m_s, MAXV, 1'b1, 3, r, ld, lv, e, ud, st, clr);
    q_w.push_back(to_exp(m_w, cv));
    q_s.push_back(to_exp(m_s, cv));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: after every edge, compare whatever the scoreboards predicted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        chk("w_count", w_count, e.cnt);
        chk("w_ovf_pulse", w_ovf, e.ovf);
        chk("w_unf_pulse", w_unf, e.unf);
        chk("w_ovf_sticky", w_ovfs, e.ovfs);
        chk("w_unf_sticky", w_unfs, e.unfs);
        chk("w_match", w_match, (e.cnt == e.cmp) ? 1 : 0);
      end
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        chk("s_count", s_count, e.cnt);
        chk("s_ovf_pulse", s_ovf, e.ovf);
        chk("s_unf_pulse", s_unf, e.unf);
        chk("s_ovf_sticky", s_ovfs, e.ovfs);
        chk("s_unf_sticky", s_unfs, e.unfs);
        chk("s_match", s_match, (e.cnt == e.cmp) ? 1 : 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; updown = 1'b0; clr_flags = 1'b0;
    load_val = '0; step = '0; cmp_val = '0;
    m_w = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    m_s = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset, then count up by one through the wrap point.
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 1, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 1, 0, 1'b0);
    repeat (12) drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 0, 1'b0);
    settle();
    chk("t1_count", w_count, 2);
    chk("t1_ovf_sticky", w_ovfs, 1);

    // Down by three from 2, with a flag clear colliding with a new underflow.
    drive(1'b0, 1'b1, 2, 1'b0, 1'b0, 3, 0, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 3, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0, 3, 0, 1'b1);
    settle();
    chk("t2_count", w_count, 7);
    chk("t2_unf_pulse", w_unf, 1);
    chk("t2_unf_sticky", w_unfs, 1);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 3, 0, 1'b1);
    settle();
    chk("t2_cleared", w_unfs, 0);

    // Saturating counter clamps at the top rail and re-pulses each tick.
    drive(1'b0, 1'b1, 8, 1'b0, 1'b1, 5, 0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 5, 0, 1'b0);
      settle();
      chk("t3_sat_count", s_count, (i >= 3) ? 9 : 8);
      chk("t3_sat_ovf", s_ovf, (i % 3 == 0) ? 1 : 0);
    end

    // Prescaler phase survives en=0 and is restarted by load.
    drive(1'b0, 1'b1, 0, 1'b0, 1'b1, 1, 0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 0, 1'b0);
    settle();
    chk("t4_phase_hold", s_count, 1);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 0, 1'b0);
    drive(1'b0, 1'b1, 5, 1'b1, 1'b1, 1, 0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 0, 1'b0);
    settle();
    chk("t4_phase_reset", s_count, 5);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 0, 1'b0);
    settle();
    chk("t4_tick_after_load", s_count, 6);

    // Load beats tick, load value clamped, match visible immediately.
    drive(1'b0, 1'b1, 15, 1'b1, 1'b1, 1, 9, 1'b0);
    settle();
    chk("t5_count", w_count, 9);
    chk("t5_ovf_pulse", w_ovf, 0);
    chk("t5_match", w_match, 1);
    chk("t5_sat_count", s_count, 9);

    // Reset overrides a simultaneous load and tick.
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1, 0, 1'b0);
    drive(1'b1, 1'b1, 5, 1'b1, 1'b1, 1, 0, 1'b0);
    settle();
    chk("t6_count", w_count, 0);
    chk("t6_ovf_sticky", w_ovfs, 0);
    chk("t6_sat_sticky", s_ovfs, 0);

    // Randomised traffic.
    repeat (2000) begin
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", q_w.size() + q_s.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
